// File: rtl/scan_pkg.sv
// Shared types and helpers for the scan chain controller.
package scan_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCapture = 3'd1,
    StShift   = 3'd2,
    StUpdate  = 3'd3,
    StDone    = 3'd4
  } scan_state_e;

  // Bits per lane; the last lane may carry pad bits above the real chain width.
  function automatic int unsigned seg_len(input int unsigned width, input int unsigned lanes);
    return (width + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/scan_lane.sv
// One serial lane: SEG-bit shift register with parallel capture load.
module scan_lane #(
  parameter int unsigned SEG = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           capture,
  input  logic           shift,
  input  logic [SEG-1:0] cap_data,
  input  logic           si,
  output logic           so,
  output logic [SEG-1:0] data
);

  logic [SEG-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (capture) begin
      shreg_d = cap_data;
    end else if (shift) begin
      shreg_d = (shreg_q << 1) | SEG'(si);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign so   = shreg_q[SEG-1];
  assign data = shreg_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Boundary-scan style chain controller: capture, multi-lane shift, update.
// Define SCAN_PARITY_EN to add a per-lane parity output over shifted-in data.
module scan_chain_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned      WIDTH       = 111,
  parameter int unsigned      LANES       = 1,
  parameter logic [WIDTH-1:0] UPDATE_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             capture_en,
  input  logic             update_en,
  input  logic [LANES-1:0] si,
  output logic [LANES-1:0] so,
  input  logic [WIDTH-1:0] dut_o,
  output logic [WIDTH-1:0] dut_i,
  output logic             busy,
  output logic             done
`ifdef SCAN_PARITY_EN
  ,
  output logic [LANES-1:0] parity
`endif
);

  localparam int unsigned SEG = seg_len(WIDTH, LANES);
  localparam int unsigned TOT = SEG * LANES;
  localparam int unsigned CW  = $clog2(SEG + 1);
  localparam logic [CW-1:0] CntLast = CW'(SEG - 1);

  scan_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             upd_q, upd_d;
  logic [WIDTH-1:0] dut_i_q, dut_i_d;
  logic [TOT-1:0]   cap_vec;
  logic [TOT-1:0]   shreg_all;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    upd_d   = upd_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          upd_d   = update_en;
          cnt_d   = '0;
          state_d = capture_en ? StCapture : StShift;
        end
      end
      StCapture: state_d = StShift;
      StShift: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = upd_q ? StUpdate : StDone;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StUpdate: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Core inputs only move on the single UPDATE cycle.
  always_comb begin
    dut_i_d = dut_i_q;
    if (state_q == StUpdate) begin
      dut_i_d = shreg_all[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      upd_q   <= 1'b0;
      dut_i_q <= UPDATE_INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      upd_q   <= upd_d;
      dut_i_q <= dut_i_d;
    end
  end

  // Pad bits above WIDTH capture as zero.
  always_comb begin
    cap_vec             = '0;
    cap_vec[WIDTH-1:0]  = dut_o;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    scan_lane #(
      .SEG(SEG)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .capture  (state_q == StCapture),
      .shift    (state_q == StShift),
      .cap_data (cap_vec[k*SEG +: SEG]),
      .si       (si[k]),
      .so       (so[k]),
      .data     (shreg_all[k*SEG +: SEG])
    );
  end

  if (TOT > WIDTH) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^shreg_all[TOT-1:WIDTH];
  end

`ifdef SCAN_PARITY_EN
  logic [LANES-1:0] par_acc_q, par_acc_d, parity_q;

  always_comb begin
    par_acc_d = par_acc_q;
    if (state_q == StIdle && start) begin
      par_acc_d = '0;
    end else if (state_q == StShift) begin
      par_acc_d = par_acc_q ^ si;
    end
  end

  // Publish on entry to DONE so parity is valid in the same cycle as done.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_acc_q <= '0;
      parity_q  <= '0;
    end else begin
      par_acc_q <= par_acc_d;
      if (state_d == StDone) begin
        parity_q <= par_acc_d;
      end
    end
  end

  assign parity = parity_q;
`endif

  assign dut_i = dut_i_q;
  assign busy  = (state_q != StIdle);
  assign done  = (state_q == StDone);

endmodule
